// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand request / result handshake bundle between a producer-consumer and the sequencer.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_add_ctrl_cla_4bit.sv
// Combinational 4-bit carry-lookahead adder used as the shared nibble datapath.
module cla_4bit
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);
    logic [NIBBLE_W-1:0] p_s;
    logic [NIBBLE_W-1:0] g_s;
    logic [NIBBLE_W-1:0] c_s;

    assign p_s = a_i ^ b_i;
    assign g_s = a_i & b_i;

    assign c_s[0] = c_i;
    assign c_s[1] = g_s[0] | (p_s[0] & c_i);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_i);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_i);
    assign c_o    = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_i);

    assign s_o = p_s ^ c_s;
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced over one shared 4-bit CLA, least-significant nibble first,
// with the inter-nibble carry held in a register.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] nib_s_s;
    logic                nib_co_s;

    assign nib_a_s = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign nib_b_s = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    cla_4bit u_cla (
        .a_i (nib_a_s),
        .b_i (nib_b_s),
        .c_i (carry_q),
        .s_o (nib_s_s),
        .c_o (nib_co_s)
    );

    // Next-state and datapath register updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is a + ~b + 1, so the inversion and the +1 are folded in here.
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = nib_s_s;
                carry_d = nib_co_s;
                if (idx_q == IDX_LAST) begin
                    cout_d  = nib_co_s;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s_s[NIBBLE_W-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench for nibble_serial_add_ctrl against an integer-arithmetic model.
module tb_nibble_serial_add_ctrl;
    localparam int W       = 16;
    localparam int LAT     = W / 4;
    localparam int TIMEOUT = 40;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned integer arithmetic on the whole words.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        longint ua, ub, sa, sb, full, r;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            full = ua - ub;
            co   = (ua >= ub);
            r    = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            co   = (full >= (longint'(1) << W));
            r    = sa + sb + longint'(cin);
        end
        s  = full[W-1:0];
        ov = (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input string name);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n;
        model(a, b, cin, sub, es, ec, eo);
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready timeout: got %b want 1", name, bus.in_ready);
        else pass_cnt++;
        bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = sub; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n !== LAT) $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
        else pass_cnt++;
        total_cnt++;
        if (bus.sum !== es) $display("FAIL %s sum: got %h want %h", name, bus.sum, es);
        else pass_cnt++;
        total_cnt++;
        if (bus.cout !== ec) $display("FAIL %s cout: got %b want %b", name, bus.cout, ec);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== eo) $display("FAIL %s overflow: got %b want %b", name, bus.overflow, eo);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL %s out_valid after accept: got %b want 0", name, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({bus.sum, bus.cout, bus.overflow} !== {W'(0), 1'b0, 1'b0})
            $display("FAIL reset result: got %h/%b/%b want 0/0/0", bus.sum, bus.cout, bus.overflow);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset release in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "add_plain");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple_b1");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "ripple_cin");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_neg");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] es, ys;
        logic         ec, eo, yc, yo;
        logic [W-1:0] ya, yb;
        int           n;
        model(16'h4321, 16'h1357, 1'b1, 1'b0, es, ec, eo);
        ya = W'($urandom); yb = W'($urandom);
        model(ya, yb, 1'b0, 1'b1, ys, yc, yo);
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        bus.a = 16'h4321; bus.b = 16'h1357; bus.cin = 1'b1; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
        total_cnt++;
        if (n !== LAT) $display("FAIL bp latency: got %0d want %0d", n, LAT);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom); bus.op_sub = 1'($urandom);
            total_cnt++;
            if ({bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.overflow} !== {1'b1, 1'b0, es, ec, eo})
                $display("FAIL bp hold cycle %0d: got v=%b r=%b %h/%b/%b want v=1 r=0 %h/%b/%b",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.overflow, es, ec, eo);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.a = ya; bus.b = yb; bus.cin = 1'b0; bus.op_sub = 1'b1;
        total_cnt++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL bp idle cycle: got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
        total_cnt++;
        if (n !== LAT) $display("FAIL bp second latency: got %0d want %0d", n, LAT);
        else pass_cnt++;
        total_cnt++;
        if ({bus.sum, bus.cout, bus.overflow} !== {ys, yc, yo})
            $display("FAIL bp second result: got %h/%b/%b want %h/%b/%b",
                     bus.sum, bus.cout, bus.overflow, ys, yc, yo);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        int seen_valid;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL midrst in_ready during rst: got %b want 0", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.sum, bus.in_ready} !== {1'b0, W'(0), 1'b1})
            $display("FAIL midrst after: got v=%b sum=%h r=%b want v=0 sum=0000 r=1",
                     bus.out_valid, bus.sum, bus.in_ready);
        else pass_cnt++;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        total_cnt++;
        if (seen_valid !== 0) $display("FAIL midrst aborted result: got %0d valid cycles want 0", seen_valid);
        else pass_cnt++;
        run_op(16'h0100, 16'h0200, 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit carry-lookahead adder over WIDTH/4 nibbles, least-significant first, with carry registered between cycles. It accepts operands on a valid/ready input handshake and returns the registered result on a valid/ready output handshake. It trades latency for area in wide arithmetic paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. An elaboration-time check fails the build otherwise.
NIB (localparam), WIDTH/4, nibble count; sets the RUN cycle count.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand request
in_ready  out  1  controller can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for add; ignored when op_sub=1
op_sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, registered
cout  out  1  carry out of bit WIDTH-1; for subtract, 1 means no borrow
overflow  out  1  signed two's-complement overflow

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, nibble index=0, carry=0, sum=0, cout=0, overflow=0, out_valid=0. in_ready=0 while rst=1.
- Mid-operation reset: aborts the operation. No out_valid is produced for the aborted operands.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE).
- IDLE:
  - On the in_valid&&in_ready edge, latch a_r=a and b_r = op_sub ? ~b : b.
  - Latch carry = op_sub ? 1 : cin. Latch msb_a=a[WIDTH-1] and msb_b=b_r[WIDTH-1].
  - Set idx=0 and go to RUN.
- RUN:
  - Each cycle, the adder sees a_r[4*idx+:4], b_r[4*idx+:4] and carry.
  - On the edge, sum[4*idx+:4] <= s and carry <= adder cout, then idx++.
  - At idx==NIB-1: cout <= adder cout; overflow <= (msb_a==msb_b) && (s[3]!=msb_a); go to DONE.
- DONE:
  - sum, cout and overflow are stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
  - sum, cout and overflow then hold their values until the next operation overwrites them. Nibbles are overwritten progressively during RUN.
- Latency: acceptance at edge k; out_valid=1 in the cycle after edge k+NIB.
- Throughput: one operation per NIB+2 cycles with out_ready=1. No overlap: in_ready=0 in RUN and DONE, and in_valid is ignored there.
- Input operands need only be valid during the accepting cycle.
- Simultaneous events: rst has priority over every handshake.
- Wrap-around: a carry or borrow out of the top nibble appears only on cout. sum is modulo 2^WIDTH.
- Width rules:
  - idx is $clog2(NIB) bits; it never exceeds NIB-1, and no wrap occurs because the state leaves RUN at NIB-1.
  - With WIDTH=16, the top nibble is idx=3.

Decomposition:
- Package nibble_add_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the constant NIBBLE_W=4.
- One sub-module: the existing cla_4bit, instantiated once as the shared nibble datapath. It is purely combinational.
- All sequencing, operand/carry registers and the result register live in nibble_serial_add_ctrl.

Test Plan:
- Plain add, WIDTH=16: a=0x1234, b=0x1111, cin=0, op_sub=0, accepted at edge k -> out_valid at the cycle after edge k+4; sum=0x2345, cout=0, overflow=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Subtract: a=0x0005, b=0x0007, op_sub=1, cin=1 -> sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001, op_sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- Signed overflow on add: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with new operands throughout.
  - Required: out_valid, sum, cout and overflow are stable; in_ready=0; the new operands are not accepted.
  - After release: one cycle in IDLE, then the new operands are accepted.
- Reset mid-RUN: assert rst for 1 cycle at idx=2 -> after that edge, state=IDLE, out_valid=0, sum=0, in_ready=0 during rst and 1 after. A following 0x0100+0x0200 gives 0x0300.
